// File: rtl/dem_pn_scheduler.sv
// dem_pn_scheduler
//   Sequencing controller for the DEM-DAC switching-block tree. It accepts
//   codes over a valid/ready handshake and registers each code together with
//   a swap vector. Each bit of the vector drives the pn input of one
//   switching block. The swap vector is fresh pseudo-random data while DEM is
//   running, and zero (static mapping) while DEM is disabled.
//
//   Optional feature macro: DEM_SEED_LOAD_EN (adds seed_i / seed_load_i).
//
// Ports
//   clk_i        in  1       clock
//   reset_i      in  1       asynchronous active-low reset
//   x_in_i       in  WIDTH   input code
//   x_valid_i    in  1       input code valid
//   x_ready_o    out 1       a code can be accepted this cycle
//   dem_en_i     in  1       DEM randomisation enable (level)
//   seed_i       in  16      LFSR seed            (DEM_SEED_LOAD_EN only)
//   seed_load_i  in  1       seed load strobe     (DEM_SEED_LOAD_EN only)
//   x_out_o      out WIDTH   registered code to the tree root
//   pn_vec_o     out NUM_SB  registered swap bits, bit k -> block k (BFS order)
//   valid_o      out 1       one-cycle strobe for a new x_out_o/pn_vec_o pair
module dem_pn_scheduler #(
  parameter int unsigned WIDTH      = 5,
  parameter int unsigned LEVELS     = 3,
  parameter int unsigned NUM_SB     = 2**LEVELS - 1,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int unsigned WARMUP_CYC = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [WIDTH-1:0]  x_in_i,
  input  logic              x_valid_i,
  output logic              x_ready_o,
  input  logic              dem_en_i,
`ifdef DEM_SEED_LOAD_EN
  input  logic [15:0]       seed_i,
  input  logic              seed_load_i,
`endif
  output logic [WIDTH-1:0]  x_out_o,
  output logic [NUM_SB-1:0] pn_vec_o,
  output logic              valid_o
);

  localparam int unsigned CW = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN} state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [15:0]       r_lfsr, w_lfsr_nxt;
  logic [WIDTH-1:0]  r_x;
  logic [NUM_SB-1:0] r_pn;
  logic              r_valid;
  logic              w_accept;

  // NUM_SB Fibonacci steps (x^16+x^14+x^13+x^11+1) unrolled into one cycle,
  // so consecutive vectors never share bits.
  function automatic logic [15:0] f_advance(input logic [15:0] s);
    logic [15:0] v;
    v = s;
    for (int unsigned i = 0; i < NUM_SB; i++)
      v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    return v;
  endfunction

  // Ready is forced low while reset is held, independent of the state.
  assign x_ready_o = reset_i & (r_state != S_WARMUP);
  assign w_accept  = x_valid_i & x_ready_o;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lfsr_nxt  = r_lfsr;
    case (r_state)
      S_IDLE: begin
`ifdef DEM_SEED_LOAD_EN
        // A zero seed would lock the LFSR up; fall back to SEED.
        if (seed_load_i)
          w_lfsr_nxt = (seed_i == '0) ? SEED : seed_i;
`endif
        if (dem_en_i) begin
          w_state_nxt = S_WARMUP;
          w_cnt_nxt   = '0;
        end
      end
      S_WARMUP: begin
        w_lfsr_nxt = f_advance(r_lfsr);
        if (!dem_en_i) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CW'(WARMUP_CYC - 1)) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (w_accept)
          w_lfsr_nxt = f_advance(r_lfsr);
        if (!dem_en_i)
          w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_lfsr  <= SEED;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lfsr  <= w_lfsr_nxt;
    end
  end

  // The swap vector is taken from the LFSR value before this accept's advance.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_x     <= '0;
      r_pn    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_x  <= x_in_i;
        r_pn <= (r_state == S_RUN) ? r_lfsr[NUM_SB-1:0] : '0;
      end
    end
  end

  assign x_out_o  = r_x;
  assign pn_vec_o = r_pn;
  assign valid_o  = r_valid;

endmodule

// File: tb/tb_dem_pn_scheduler.sv
module tb_dem_pn_scheduler;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b0;
  logic [4:0] x_in_i = '0;
  logic       x_valid_i = 1'b0;
  logic       x_ready_o;
  logic       dem_en_i = 1'b0;
`ifdef DEM_SEED_LOAD_EN
  logic [15:0] seed_i = '0;
  logic        seed_load_i = 1'b0;
`endif
  logic [4:0] x_out_o;
  logic [6:0] pn_vec_o;
  logic       valid_o;

  dem_pn_scheduler #(
    .WIDTH(5), .LEVELS(3), .NUM_SB(7), .SEED(SEED), .WARMUP_CYC(16)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .x_in_i(x_in_i), .x_valid_i(x_valid_i),
    .x_ready_o(x_ready_o), .dem_en_i(dem_en_i),
`ifdef DEM_SEED_LOAD_EN
    .seed_i(seed_i), .seed_load_i(seed_load_i),
`endif
    .x_out_o(x_out_o), .pn_vec_o(pn_vec_o), .valid_o(valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [4:0] x;
    logic [6:0] pn;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] m_lfsr = SEED;
  bit          m_run = 0;

  // Reference: 7 single steps of x^16+x^14+x^13+x^11+1 per advance.
  function automatic logic [15:0] ref_adv(input logic [15:0] s);
    logic [15:0] v;
    v = s;
    for (int i = 0; i < 7; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] code);
    exp_t e;
    e.x  = code;
    e.pn = m_run ? m_lfsr[6:0] : 7'd0;
    q.push_back(e);
    if (m_run) m_lfsr = ref_adv(m_lfsr);
  endtask

  task automatic send(input logic [4:0] code);
    int n;
    n = 0;
    while (!x_ready_o && n < 50) begin
      n++;
      tick();
    end
    if (!x_ready_o) check("send_ready_timeout", {31'd0, x_ready_o}, 32'd1);
    x_in_i    = code;
    x_valid_i = 1'b1;
    push_exp(code);
    tick();
    x_valid_i = 1'b0;
  endtask

  // Called right after dem_en_i is raised in IDLE; returns cycles with ready low.
  task automatic warmup(output int cyc);
    tick();
    cyc = 0;
    while (!x_ready_o && cyc < 100) begin
      cyc++;
      m_lfsr = ref_adv(m_lfsr);
      tick();
    end
  endtask

  // Scoreboard monitor: pops one expectation per output strobe.
  always @(negedge clk_i) begin
    if (reset_i && valid_o) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got x=%0h pn=%0h expected no strobe", x_out_o, pn_vec_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("x_out", {27'd0, x_out_o}, {27'd0, e.x});
        check("pn_vec", {25'd0, pn_vec_o}, {25'd0, e.pn});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic run_warmup_and_codes();
    int cyc;
    dem_en_i = 1'b1;
    warmup(cyc);
    check("warmup_len", cyc, 16);
    m_run = 1;
    send(5'd7);  tick();
    send(5'd9);  tick(); tick();
    send(5'd10);
    send(5'd12); tick();
  endtask

  task automatic to_idle();
    dem_en_i = 1'b0;
    tick();
    m_run = 0;
  endtask

  initial begin
    int cyc;
    // Reset held for 3 cycles
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", {31'd0, x_ready_o}, 32'd0);
    check("rst_xout", {27'd0, x_out_o}, 32'd0);
    check("rst_pn", {25'd0, pn_vec_o}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    #3 reset_i = 1'b1;
    tick();
    check("idle_ready", {31'd0, x_ready_o}, 32'd1);

    // IDLE bypass, back-to-back
    send(5'd3); send(5'd5); send(5'd4); tick();

    // Warm-up aborted at cycle 8
    dem_en_i = 1'b1;
    tick();
    repeat (8) begin m_lfsr = ref_adv(m_lfsr); tick(); end
    check("warmup_mid_ready", {31'd0, x_ready_o}, 32'd0);
    dem_en_i = 1'b0;
    m_lfsr = ref_adv(m_lfsr);
    tick();
    check("abort_ready", {31'd0, x_ready_o}, 32'd1);
    send(5'd6);

    // Full warm-up with a code held (ignored) while not ready
    dem_en_i = 1'b1;
    tick();
    x_in_i = 5'd21;
    x_valid_i = 1'b1;
    cyc = 0;
    while (!x_ready_o && cyc < 100) begin
      cyc++;
      m_lfsr = ref_adv(m_lfsr);
      tick();
    end
    check("rewarmup_len", cyc, 16);
    m_run = 1;
    push_exp(5'd21);
    tick();
    x_valid_i = 1'b0;

    // RUN with gaps
    send(5'd7);  tick(); tick(); tick();
    send(5'd9);  tick();
    send(5'd10);
    send(5'd12); tick(); tick();

    // dem_en fall together with an accept
    x_in_i = 5'd1; x_valid_i = 1'b1; dem_en_i = 1'b0;
    push_exp(5'd1);
    tick();
    x_valid_i = 1'b0;
    m_run = 0;
    send(5'd2); tick();

    // Mid-run reset kills the pending strobe
    run_warmup_and_codes();
    x_in_i = 5'd13; x_valid_i = 1'b1;
    tick();
    x_valid_i = 1'b0;
    check("pre_reset_valid", {31'd0, valid_o}, 32'd1);
    reset_i = 1'b0;
    dem_en_i = 1'b0;
    #1;
    check("midrst_xout", {27'd0, x_out_o}, 32'd0);
    check("midrst_pn", {25'd0, pn_vec_o}, 32'd0);
    check("midrst_valid", {31'd0, valid_o}, 32'd0);
    check("midrst_ready", {31'd0, x_ready_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    #3 reset_i = 1'b1;
    m_lfsr = SEED; m_run = 0;
    tick();
    run_warmup_and_codes();
    to_idle();

`ifdef DEM_SEED_LOAD_EN
    // Zero seed falls back to SEED
    seed_i = 16'h0000; seed_load_i = 1'b1;
    tick();
    seed_load_i = 1'b0;
    m_lfsr = SEED;
    run_warmup_and_codes();
    to_idle();
    // Explicit seed
    seed_i = 16'h1234; seed_load_i = 1'b1;
    tick();
    seed_load_i = 1'b0;
    m_lfsr = 16'h1234;
    run_warmup_and_codes();
    // Load strobe in RUN is ignored
    seed_i = 16'h5555; seed_load_i = 1'b1;
    tick();
    seed_load_i = 1'b0;
    send(5'd17); send(5'd18); tick();
    to_idle();
`endif

    repeat (3) tick();
    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dem_pn_scheduler.md
# dem_pn_scheduler

Sequencing controller for the DEM-DAC switching-block tree. It accepts input codes through a valid/ready handshake and registers each code with a fresh pseudo-random swap vector. That vector supplies the `pn_seq_i` bit of every switching block in the tree. It owns the LFSR, its warm-up after DEM enable, and a static-mapping bypass when DEM is disabled.

## Interface
- `WIDTH`, 5: input code width, which is the tree root input width.
- `LEVELS`, 3: number of switching-block tree levels.
- `NUM_SB`, 2**LEVELS-1: number of switching blocks, one pn bit each. Must be ≤ 16.
- `SEED`, 16'hACE1: LFSR reset value. Must be non-zero.
- `WARMUP_CYC`, 16: number of LFSR advance cycles after DEM enable.

Ports:
- `clk_i` in 1: clock.
- `reset_i` in 1: asynchronous, active-low reset.
- `x_in_i` in WIDTH: input code.
- `x_valid_i` in 1: input code valid.
- `x_ready_o` out 1: block can accept a code this cycle.
- `dem_en_i` in 1: DEM randomisation enable, level-sensitive.
- `seed_i` in 16: LFSR seed value. Present only with the macro (see Configuration).
- `seed_load_i` in 1: seed load strobe. Present only with the macro.
- `x_out_o` out WIDTH: registered code to the tree root.
- `pn_vec_o` out NUM_SB: registered swap bits. Bit k drives switching block k, numbered breadth-first from the root (k=0).
- `valid_o` out 1: one-cycle strobe marking a new `x_out_o`/`pn_vec_o` pair.

## Operation
- **LFSR:** 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - One step is `lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}`.
  - An "advance" applies NUM_SB steps in a single cycle (unrolled), so every emitted vector consists of fresh bits.
- **FSM states:** IDLE, WARMUP, RUN. Reset state is IDLE.
- **IDLE:**
  - `x_ready_o`=1.
  - Each accepted code produces `pn_vec_o`=0 (static mapping).
  - LFSR is frozen.
  - `dem_en_i`=1 moves to WARMUP on the next edge. A code accepted in that same cycle is still emitted with pn=0.
- **WARMUP:**
  - `x_ready_o`=0.
  - LFSR advances every cycle.
  - A counter runs from 0 to WARMUP_CYC-1; the state moves to RUN after exactly WARMUP_CYC cycles.
  - If `dem_en_i` drops during WARMUP, return to IDLE immediately on the next edge. The counter clears.
- **RUN:**
  - `x_ready_o`=1.
  - On each accepted code (`x_valid_i & x_ready_o`):
    - `pn_vec_o` <= current `lfsr[NUM_SB-1:0]`.
    - LFSR advances.
  - No advance on idle cycles.
  - `dem_en_i`=0 moves to IDLE on the next edge. A code accepted in that cycle still uses LFSR bits.
- **Outputs when no code is accepted:** `x_out_o` and `pn_vec_o` hold their last values; `valid_o`=0.
- **Backpressure:** none from downstream; the DAC consumes every strobe.
- **Code value:** `x_out_o` is `x_in_i` unmodified. No arithmetic is applied to the code.

## Timing
- **Latency:** 1 cycle from accept edge to `valid_o`. Full throughput of one code per cycle in IDLE and RUN.
- **Reset values:**
  - `x_out_o`=0, `pn_vec_o`=0, `valid_o`=0.
  - `x_ready_o`=0 while `reset_i`=0, then 1 once in IDLE.
  - lfsr=SEED, warm-up counter=0.
- **Reset mid-operation:** asserting `reset_i` in any state clears all state asynchronously. A pending output strobe is lost.
- **`x_valid_i` while `x_ready_o`=0:** ignored. The producer must hold the code and retry.
- **Simultaneous `dem_en_i` fall and accept in RUN:** the accept completes with LFSR bits. The next code uses pn=0.

## Configuration
- Macro: `DEM_SEED_LOAD_EN`.
- **Defined:**
  - `seed_i` and `seed_load_i` exist.
  - `seed_load_i`=1 in IDLE loads the LFSR on the next edge. A zero `seed_i` loads SEED instead, to avoid lock-up.
  - In WARMUP and RUN the strobe is ignored.
- **Undefined:** both ports are absent. The LFSR only ever starts from SEED.

## Test plan
- **Reset:** hold `reset_i`=0 for 3 cycles, then release → all outputs 0, then `x_ready_o`=1, state IDLE.
- **IDLE bypass:** `dem_en_i`=0; send codes 3, 5, 4 back-to-back → `x_out_o` = 3, 5, 4 on consecutive cycles, one cycle late; `pn_vec_o`=0; `valid_o`=1 for 3 cycles.
- **Warm-up:** raise `dem_en_i` → `x_ready_o`=0 for exactly 16 cycles, then 1. Drop `dem_en_i` at warm-up cycle 8 → IDLE; a re-raise restarts the full 16-cycle warm-up.
- **RUN sequence:** after warm-up, send codes 7, 9, 10, 12 with `x_valid_i` gaps → each `pn_vec_o` matches a reference LFSR model that has advanced 7 steps per accept and by 16 warm-up advances. No LFSR change during gaps.
- **Seed load (macro on):** `seed_i`=0 plus load, then warm-up and 4 codes → vectors identical to the post-reset run. `seed_i`=16'h1234 → vectors match the model seeded with 1234. A load strobe in RUN has no effect.
- **Mid-run reset:** assert `reset_i` while `valid_o`=1 in RUN → outputs 0 immediately; after release, the first RUN vectors match the post-reset sequence.
